// File: rtl/rs_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler_if
// Description : Bundle between the reservation-station heads, the shared
//               functional units and rs_issue_scheduler.
//               slave  modport : the scheduler (consumes requests, drives
//                                pops and FU issue selects)
//               master modport : the surrounding pipeline / testbench
//               Signals:
//                 rs_valid       RS head entry valid
//                 rs_ops_ready   RS head operands all resolved
//                 rs_fu_sel      target FU index of each RS head (flattened)
//                 rs_pop         pop grant to each RS (combinational)
//                 fu_ready       FU can accept a new op
//                 fu_issue_valid registered issue strobe per FU
//                 fu_issue_src   registered RS index per FU (flattened)
//                 fu_busy        FU occupancy counter nonzero
//                 flush          pipeline flush
//               Optional macro RS_SCHED_PERF_EN adds perf_issue_cnt and
//               perf_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_issue_scheduler_if #(
    parameter int NUM_RS   = 4,
    parameter int NUM_FU   = 2,
    parameter int RS_IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
    parameter int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
    logic [NUM_RS-1:0]          rs_valid;
    logic [NUM_RS-1:0]          rs_ops_ready;
    logic [NUM_RS*FU_IDX_W-1:0] rs_fu_sel;
    logic [NUM_RS-1:0]          rs_pop;
    logic [NUM_FU-1:0]          fu_ready;
    logic [NUM_FU-1:0]          fu_issue_valid;
    logic [NUM_FU*RS_IDX_W-1:0] fu_issue_src;
    logic [NUM_FU-1:0]          fu_busy;
    logic                       flush;
`ifdef RS_SCHED_PERF_EN
    logic [31:0]                perf_issue_cnt;
    logic [31:0]                perf_stall_cnt;
`endif

    modport slave (
        input  rs_valid, rs_ops_ready, rs_fu_sel, fu_ready, flush,
        output rs_pop, fu_issue_valid, fu_issue_src, fu_busy
`ifdef RS_SCHED_PERF_EN
        , output perf_issue_cnt, perf_stall_cnt
`endif
    );

    modport master (
        output rs_valid, rs_ops_ready, rs_fu_sel, fu_ready, flush,
        input  rs_pop, fu_issue_valid, fu_issue_src, fu_busy
`ifdef RS_SCHED_PERF_EN
        , input perf_issue_cnt, perf_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler
// Description : Round-robin issue arbiter between NUM_RS reservation-station
//               heads and NUM_FU shared non-pipelined functional units.
//               Per FU, one requesting RS with resolved operands is granted
//               each cycle; the pop is combinational, the issue select to the
//               FU operand mux is registered, and a latency counter blocks
//               further grants while the FU is occupied.
// Ports       : clk  - clock
//               rst  - synchronous active-low reset
//               bus  - rs_issue_scheduler_if.slave (requests, pops, issue)
// Options     : RS_SCHED_PERF_EN - adds 32-bit issue / stall perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int NUM_RS     = 4,
    parameter int NUM_FU     = 2,
    parameter int FU_LATENCY = 3,
    parameter int RS_IDX_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
    parameter int FU_IDX_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rs_issue_scheduler_if.slave   bus
);

    localparam int c_CNT_W = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;

    logic [NUM_FU-1:0][c_CNT_W-1:0]  r_busy_cnt;
    logic [NUM_FU-1:0][RS_IDX_W-1:0] r_rr_ptr;
    logic [NUM_FU-1:0][RS_IDX_W-1:0] r_issue_src;
    logic [NUM_FU-1:0]               r_issue_valid;

    logic [NUM_RS-1:0][NUM_FU-1:0]   w_req;
    logic [NUM_FU-1:0]               w_avail;
    logic [NUM_FU-1:0][NUM_RS-1:0]   w_grant;
    logic [NUM_FU-1:0]               w_grant_any;
    logic [NUM_FU-1:0][RS_IDX_W-1:0] w_win;
    logic [NUM_FU-1:0][RS_IDX_W-1:0] w_ptr_nxt;
    logic [NUM_RS-1:0]               w_pop;

    // An out-of-range rs_fu_sel matches no FU and therefore never requests.
    always_comb begin : p_req
        w_req = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            for (int f = 0; f < NUM_FU; f++) begin
                w_req[r][f] = bus.rs_valid[r] & bus.rs_ops_ready[r] &
                    (bus.rs_fu_sel[r*FU_IDX_W +: FU_IDX_W] == FU_IDX_W'(f));
            end
        end
    end

    // Reset and flush both gate availability, which keeps rs_pop at zero
    // while either is active.
    always_comb begin : p_avail
        w_avail = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_avail[f] = (r_busy_cnt[f] == '0) & bus.fu_ready[f] &
                         ~bus.flush & rst;
        end
    end

    // Round-robin scan starting at rr_ptr; first requester wins.
    always_comb begin : p_arb
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_any = '0;
        w_win       = '0;
        w_ptr_nxt   = '0;
        w_pop       = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_avail[f]) begin
                for (int k = 0; k < NUM_RS; k++) begin
                    idx = (int'(r_rr_ptr[f]) + k) % NUM_RS;
                    if (!w_grant_any[f] && w_req[idx][f]) begin
                        w_grant_any[f]  = 1'b1;
                        w_grant[f][idx] = 1'b1;
                        w_win[f]        = RS_IDX_W'(idx);
                    end
                end
            end
            w_ptr_nxt[f] = (int'(w_win[f]) == NUM_RS - 1) ? '0
                                                          : w_win[f] + RS_IDX_W'(1);
            // Each RS targets a single FU, so this OR never merges two grants.
            w_pop = w_pop | w_grant[f];
        end
    end

    always_ff @(posedge clk) begin : p_state
        if (!rst) begin
            r_busy_cnt    <= '0;
            r_rr_ptr      <= '0;
            r_issue_src   <= '0;
            r_issue_valid <= '0;
        end else if (bus.flush) begin
            // Drop in-flight occupancy; rr_ptr and issue_src are kept.
            r_busy_cnt    <= '0;
            r_issue_valid <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_grant_any[f]) begin
                    r_rr_ptr[f]      <= w_ptr_nxt[f];
                    r_busy_cnt[f]    <= c_CNT_W'(FU_LATENCY - 1);
                    r_issue_valid[f] <= 1'b1;
                    r_issue_src[f]   <= w_win[f];
                end else begin
                    r_issue_valid[f] <= 1'b0;
                    if (r_busy_cnt[f] != '0) begin
                        r_busy_cnt[f] <= r_busy_cnt[f] - c_CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin : p_busy
        bus.fu_busy = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            bus.fu_busy[f] = (r_busy_cnt[f] != '0);
        end
    end

    assign bus.rs_pop         = w_pop;
    assign bus.fu_issue_valid = r_issue_valid;
    assign bus.fu_issue_src   = r_issue_src;

`ifdef RS_SCHED_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // A stall cycle is one where some valid RS head was left un-popped.
    assign w_stall = |(bus.rs_valid & ~w_pop);

    always_ff @(posedge clk) begin : p_perf
        if (!rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else if (!bus.flush) begin
            r_perf_issue <= r_perf_issue + 32'($countones(w_pop));
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.perf_issue_cnt = r_perf_issue;
    assign bus.perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Issue arbiter between NUM_RS reservation-station pop ports (head entries) and NUM_FU shared, non-pipelined functional units.
- Each cycle, per FU, picks one requesting RS whose head operands are all resolved, round-robin.
- Asserts that RS's pop (ready_in), tracks per-FU occupancy with a latency counter, and emits a registered issue select to the FU operand mux.

Parameters:
- NUM_RS, 4, number of requesting reservation stations.
- NUM_FU, 2, number of shared functional units.
- FU_LATENCY, 3, cycles an FU is occupied per op (1 = fully pipelined).
- RS_IDX_W, $clog2(NUM_RS) (min 1), RS index width.
- FU_IDX_W, $clog2(NUM_FU) (min 1), FU index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- rs_valid  in  NUM_RS  RS head entry valid (RS valid_out[0]).
- rs_ops_ready  in  NUM_RS  head entry has pendingA/B/C all clear.
- rs_fu_sel  in  NUM_RS*FU_IDX_W  target FU index of each RS head.
- rs_pop  out  NUM_RS  pop grant to RS (drives RS ready_in[0]), combinational.
- fu_ready  in  NUM_FU  FU can accept (external stall when 0).
- fu_issue_valid  out  NUM_FU  registered: issue to FU this cycle.
- fu_issue_src  out  NUM_FU*RS_IDX_W  registered: RS index feeding FU operand mux.
- fu_busy  out  NUM_FU  occupancy counter nonzero.
- flush  in  1  pipeline flush.

Behaviour:
- req[r][f] = rs_valid[r] & rs_ops_ready[r] & (rs_fu_sel[r]==f). rs_fu_sel >= NUM_FU never requests and is never granted.
- FU f available = (busy_cnt[f]==0) & fu_ready[f] & ~flush.
- Per available FU: round-robin over r starting at rr_ptr[f]; first requester wins. grant[r][f] is one-hot per FU.
- Each RS targets one FU, so at most one grant per RS per cycle.
- rs_pop[r] = OR over f of grant[r][f]. Same cycle as the request, zero latency.
- On grant to FU f:
  - rr_ptr[f] <= (winner+1) mod NUM_RS.
  - busy_cnt[f] <= FU_LATENCY-1.
  - Next cycle: fu_issue_valid[f]=1 and fu_issue_src[f]=winner.
- Without a grant: busy_cnt[f] decrements if nonzero and saturates at 0; fu_issue_valid[f] <= 0; fu_issue_src[f] holds.
- Occupancy is not stalled by fu_ready. fu_ready gates new grants only.
- fu_busy[f] = (busy_cnt[f]!=0).
- Counter width = max(1, $clog2(FU_LATENCY)). FU_LATENCY=1 permits back-to-back grants.
- Flush: no grants in the flush cycle (rs_pop=0). Next cycle: fu_issue_valid=0 and all busy_cnt=0. rr_ptr retained.
- Flush has priority over a grant in the same cycle.
- Reset (rst=0 at clk edge), including mid-operation:
  - rs_pop=0 while in reset (combinational gate).
  - fu_issue_valid=0, fu_issue_src=0, busy_cnt=0, fu_busy=0, rr_ptr=0.
  - Perf counters=0.
- Idle (no requests): state unchanged except busy_cnt decrement.

Optional Feature:
- Macro RS_SCHED_PERF_EN.
- Defined: adds ports perf_issue_cnt out 32 and perf_stall_cnt out 32.
  - perf_issue_cnt increments by popcount(rs_pop) per cycle.
  - perf_stall_cnt increments by 1 per cycle in which any RS with rs_valid=1 is not popped.
  - Both counters wrap at 2^32, clear on reset, and are frozen during flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan (NUM_RS=4, NUM_FU=2, FU_LATENCY=3):
- Reset release; RS0 and RS2 valid+ready targeting FU0 at c0:
  - rs_pop=0001 at c0.
  - fu_issue_valid[0]=1, src=0 at c1.
  - fu_busy[0]=1 at c1-c2.
  - RS2 popped (0100) at c3; src=2 at c4.
- RS1→FU0 and RS3→FU1 same cycle, both FUs idle → rs_pop=1010; next cycle fu_issue_valid=11, src[0]=1, src[1]=3.
- RS0 valid but rs_ops_ready=0 targeting FU1, RS1 ready targeting FU1 → RS1 granted, rs_pop=0010; RS0 granted only after its ops_ready=1 and FU1 free.
- fu_ready[0]=0 for 5 cycles with RS0 requesting → rs_pop=0 throughout; grant in the first cycle fu_ready[0]=1.
- Grant at c0, flush at c1 → fu_issue_valid[0]=1 at c1; at c2 fu_busy=00 and fu_issue_valid=00; new request at c2 granted immediately.
- Flush and request in the same cycle → rs_pop=0000; rst=0 while FU0 busy → next cycle fu_busy=00, rr_ptr=0 (RS0 wins a 4-way tie).
